// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage front end.
// Pure declarations, no logic of its own.
// Not applicable: no handshakes here.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      REQ  = 1'b0,
      WAIT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   // Sequential fetch address; wraps naturally at 2^32.
   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_out_buffer.sv
// Output slot plus one skid entry feeding the fetch-to-decode register.
// Latency: a pushed word is presented the cycle after the push.
// Backpressure: stall holds the slot; a push then lands in the skid entry.
module fetch_out_buffer
   import fetch_pkg::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        flush,
   input  logic        stall,
   input  logic        push_vld,
   input  logic [31:0] push_instr,
   input  logic [31:0] push_pc,
   output logic        push_to_slot,
   output logic        skid_empty,
   output logic [31:0] Instr_F,
   output logic [31:0] PC_F,
   output logic [31:0] PC_Plus_4_F,
   output logic        Instr_Valid_F
);

   fetch_entry_t slot_q;
   fetch_entry_t skid_q;
   fetch_entry_t push_entry;
   logic         consume;
   logic         slot_open;

   assign consume      = slot_q.valid & ~stall;
   assign slot_open    = ~slot_q.valid | consume;
   // A push reaches the slot only when nothing older is waiting in the skid.
   assign push_to_slot = slot_open & ~skid_q.valid;
   assign skid_empty   = ~skid_q.valid;
   assign push_entry   = '{valid: push_vld, instr: push_instr, pc: push_pc};

   // Slot refills from the skid first, then from the incoming push.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         slot_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         slot_q.valid <= 1'b0;
         skid_q.valid <= 1'b0;
      end else if (slot_open) begin
         if (skid_q.valid) begin
            slot_q <= skid_q;
            skid_q <= push_entry;
         end else begin
            slot_q <= push_entry;
         end
      end else if (push_vld) begin
         skid_q <= push_entry;
      end
   end

   assign Instr_Valid_F = slot_q.valid;
   assign Instr_F       = slot_q.valid ? slot_q.instr : NOP_INSTR;
   assign PC_F          = slot_q.valid ? slot_q.pc : 32'd0;
   assign PC_Plus_4_F   = slot_q.valid ? pc_next(slot_q.pc) : 32'd0;

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC owner: one-outstanding imem requests, buffered F-stage outputs.
// Latency: request at cycle 0, instruction valid at cycle 2 with a 1-cycle memory.
// Backpressure: Stall_En holds the slot; skid absorbs one word, then requests stop.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        Stall_En,
   input  logic        Redirect_En,
   input  logic [31:0] Redirect_PC,
   output logic        IMem_Req_Valid,
   input  logic        IMem_Req_Ready,
   output logic [31:0] IMem_Req_Addr,
   input  logic        IMem_Rsp_Valid,
   input  logic [31:0] IMem_Rsp_Data,
   output logic [31:0] Instr_F,
   output logic [31:0] PC_F,
   output logic [31:0] PC_Plus_4_F,
   output logic        Instr_Valid_F
);

   fetch_state_t state_q;
   logic [31:0]  fetch_pc_q;
   logic [31:0]  pending_pc_q;
   logic [31:0]  req_addr_q;
   logic         kill_q;
   logic         hold_q;

   logic         rsp_hit;
   logic         rsp_keep;
   logic         push_to_slot;
   logic         skid_empty;
   logic         req_vld;
   logic         req_acc;
   logic [31:0]  req_addr;

   assign rsp_hit  = (state_q == WAIT) & IMem_Rsp_Valid;
   // Redirect beats a same-cycle response; killed responses are dropped too.
   assign rsp_keep = rsp_hit & ~kill_q & ~Redirect_En;
   assign req_acc  = req_vld & IMem_Req_Ready;

   // Request generation: a held request is never withdrawn or re-addressed.
   always_comb begin
      req_vld  = 1'b0;
      req_addr = fetch_pc_q;
      if (state_q == REQ) begin
         req_vld  = hold_q | (~Redirect_En & skid_empty);
         req_addr = hold_q ? req_addr_q : fetch_pc_q;
      end else begin
         req_vld  = rsp_keep & push_to_slot;
         req_addr = pc_next(pending_pc_q);
      end
   end

   assign IMem_Req_Valid = req_vld & RST_N;
   assign IMem_Req_Addr  = req_addr;

   // Fetch FSM with fetch PC, kill tag and held-request tracking.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= REQ;
         fetch_pc_q   <= RESET_PC;
         pending_pc_q <= 32'd0;
         req_addr_q   <= 32'd0;
         kill_q       <= 1'b0;
         hold_q       <= 1'b0;
      end else begin
         hold_q <= req_vld & ~IMem_Req_Ready;
         if (req_vld) req_addr_q <= req_addr;
         if (req_acc) pending_pc_q <= req_addr;

         case (state_q)
            REQ:     if (req_acc) state_q <= WAIT;
            WAIT:    if (rsp_hit && !req_acc) state_q <= REQ;
            default: state_q <= REQ;
         endcase

         // Any request still in flight or already issued is tagged dead.
         if (Redirect_En)
            kill_q <= ((state_q == WAIT) & ~IMem_Rsp_Valid) | req_vld;
         else if (rsp_hit)
            kill_q <= 1'b0;

         if (Redirect_En)
            fetch_pc_q <= Redirect_PC & ~32'd3;
         else if (rsp_keep)
            fetch_pc_q <= pc_next(pending_pc_q);
      end
   end

   fetch_out_buffer u_out_buffer (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .flush         (Redirect_En),
      .stall         (Stall_En),
      .push_vld      (rsp_keep),
      .push_instr    (IMem_Rsp_Data),
      .push_pc       (pending_pc_q),
      .push_to_slot  (push_to_slot),
      .skid_empty    (skid_empty),
      .Instr_F       (Instr_F),
      .PC_F          (PC_F),
      .PC_Plus_4_F   (PC_Plus_4_F),
      .Instr_Valid_F (Instr_Valid_F)
   );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage front end. Owns the fetch PC and issues one-outstanding valid/ready requests to the instruction memory.
- Buffers each returned word and presents Instr_F / PC_F / PC_Plus_4_F with a valid flag to the fetch-to-decode pipeline register.
- Honours decode stalls (Stall_En) and execute-stage redirects. Responses that belong to a redirected-away path are discarded.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Stall_En  in  1  decode stalled; presented instruction not consumed this cycle.
- Redirect_En  in  1  branch/jump taken; restart fetch at Redirect_PC.
- Redirect_PC  in  32  redirect target; bits [1:0] ignored, treated as 00.
- IMem_Req_Valid  out  1  request valid.
- IMem_Req_Ready  in  1  memory accepts the request this cycle.
- IMem_Req_Addr  out  32  word-aligned fetch address.
- IMem_Rsp_Valid  in  1  response data valid (exactly one per accepted request, in order, ≥1 cycle after acceptance).
- IMem_Rsp_Data  in  32  instruction word.
- Instr_F  out  32  presented instruction; 32'h00000013 (NOP) when not valid.
- PC_F  out  32  PC of the presented instruction; 0 when not valid.
- PC_Plus_4_F  out  32  PC_F+4, mod 2^32; 0 when not valid.
- Instr_Valid_F  out  1  presented instruction is valid.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - Fetch_PC=RESET_PC.
  - FSM=REQ, Kill=0, slot and skid empty.
  - Instr_Valid_F=0, Instr_F=NOP, PC_F=0, PC_Plus_4_F=0, IMem_Req_Valid=0 while in reset.
  - The memory is reset by the same RST_N. No stale response is expected after reset.
- Storage:
  - Output slot {valid, instr, pc} drives the F outputs directly.
  - One skid entry behind the slot.
  - Slot is consumed on any cycle with slot.valid=1 and Stall_En=0.
  - Skid moves into the slot when the slot is consumed or empty.
- FSM states:
  - REQ: IMem_Req_Valid=1 iff the skid is empty and (slot empty, or slot consumed this cycle, or FSM has no pending data). IMem_Req_Addr=Fetch_PC. On Valid&&Ready → WAIT, Pending_PC=Fetch_PC.
  - WAIT: wait for IMem_Rsp_Valid. Kill=1: drop data, clear Kill, → REQ. Kill=0: write {1, Rsp_Data, Pending_PC} into the slot if free or consumed this cycle, else into the skid. Fetch_PC=Pending_PC+4.
  - Back-to-back issue: in the response cycle, if the data went to the slot and the skid is empty, IMem_Req_Valid may assert the same cycle with address Pending_PC+4. On accept, stay in WAIT; otherwise → REQ. This gives 1 instr/cycle with a zero-wait, 1-cycle-latency memory.
- Request stability: once IMem_Req_Valid=1, address and valid are held until Ready, including across a redirect.
- Redirect_En (priority over stall and over response writes in the same cycle):
  - Slot and skid invalidated; Instr_Valid_F=0 next cycle.
  - Fetch_PC=Redirect_PC & ~3.
  - Kill=1 if a request is outstanding, accepted this cycle, or pending unaccepted in REQ. An unaccepted request completes, is tagged killed, and its response is dropped; fetch then re-requests Fetch_PC.
  - A second redirect while Kill=1 only updates Fetch_PC.
- Fetch_PC wraps 32'hFFFF_FFFC → 0. PC_Plus_4_F of 32'hFFFF_FFFC is 0.
- Simultaneous events:
  - Stall_En with response arrival and slot full: data goes to the skid, and no new request is issued until the skid drains.
  - Stall_En with Redirect_En: redirect wins.
- Latency after reset release, with Ready=1 and 1-cycle response:
  - Req_Valid=1 at cycle 0.
  - Instr_Valid_F=1 at cycle 2 with PC_F=RESET_PC.

Decomposition:
- fetch_pkg:
  - NOP_INSTR=32'h00000013.
  - fetch_state_t enum {REQ, WAIT}.
  - fetch_entry_t struct {valid, instr[31:0], pc[31:0]}.
- Sub-module fetch_out_buffer: slot plus skid, with push/consume/flush and full/empty flags, driving the F outputs.
- FSM, Fetch_PC, Kill and Pending_PC stay in fetch_unit.

Test Plan:
- Reset with RESET_PC=0x100, memory Ready=1 and 1-cycle latency, no stalls -> requests 0x100, 0x104, 0x108 on consecutive cycles; Instr_Valid_F=1 from cycle 2; PC_F increments by 4 each cycle; PC_Plus_4_F=PC_F+4.
- Stall_En high 3 cycles while a response returns -> slot holds PC 0x104, skid captures 0x108, Req_Valid=0 until Stall_En drops; then 0x104 and 0x108 are presented on consecutive cycles with no loss or duplication.
- Redirect_En to 0x2002 while a request for 0x10C is outstanding -> the 0x10C response is dropped, Instr_Valid_F=0, next request address is 0x2000, next valid PC_F is 0x2000.
- Redirect_En while Req_Valid=1 and Ready=0 for 4 cycles -> address stays 0x10C until accepted, its response is discarded, then 0x2000 is requested.
- Fetch_PC=0xFFFFFFFC -> PC_Plus_4_F=0, next request address 0x00000000.
- Async RST_N pulse mid-WAIT (not clock-aligned) -> outputs are immediately NOP/0/0/valid 0; after release fetch restarts at RESET_PC.
